// File: rtl/cntr8_cmd_seq.sv
// cntr8_cmd_seq: queued command sequencer driving the cntr8 load/inc/d_in inputs
//
// Buffers LOAD/UP/DOWN/NOP commands in a DEPTH-entry FIFO and expands each one
// into per-cycle counter drive. Build option: define CNTR8_CMD_SEQ_OVF_EN to
// enable the sticky overflow flag on o_err (tied to 0 otherwise).
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake; cmd_ready depends on occupancy only
//   cmd_op, cmd_arg     00 NOP, 01 LOAD value, 10 UP count, 11 DOWN count (0 = 256)
//   i_hold              pause: drive forced to 0, execution frozen
//   o_load/o_inc/o_d_in counter drive
//   o_busy              a command is executing
//   o_level             FIFO occupancy
//   o_err               sticky rejected-push flag (optional)
module cntr8_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [7:0]    cmd_arg,
    input  logic          i_hold,
    output logic          o_load,
    output logic          o_inc,
    output logic [7:0]    o_d_in,
    output logic          o_busy,
    output logic [AW:0]   o_level,
    output logic          o_err
);
    typedef enum logic {IDLE, EXEC} state_t;
    localparam logic [1:0]  OP_NOP  = 2'd0;
    localparam logic [1:0]  OP_LOAD = 2'd1;
    localparam logic [1:0]  OP_UP   = 2'd2;
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    state_t        state_q;
    logic [1:0]    op_q;
    logic [7:0]    arg_q;
    logic [8:0]    rem_q;
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   level_q, level_d;
    logic [9:0]    head;
    logic          push, pop, last, run;
    assign cmd_ready = level_q != FULL;
    assign push      = cmd_valid & cmd_ready;
    assign run       = (state_q == EXEC) & ~i_hold;
    // LOAD and NOP always last one cycle; UP/DOWN end when one step remains
    assign last      = (op_q == OP_LOAD) | (op_q == OP_NOP) | (rem_q == 9'd1);
    // pop from IDLE, or on the final EXEC cycle so commands chain without a bubble
    assign pop       = ~i_hold & (level_q != '0) & ((state_q == IDLE) | last);
    assign level_d   = level_q + (AW+1)'(push) - (AW+1)'(pop);
    assign head      = mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {cmd_op, cmd_arg};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            arg_q   <= 8'd0;
            rem_q   <= 9'd0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            level_q <= level_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q    <= rd_q + 1'b1;
                op_q    <= head[9:8];
                arg_q   <= head[7:0];
                rem_q   <= (head[7:0] == 8'd0) ? 9'd256 : {1'b0, head[7:0]};
                state_q <= EXEC;
            end else if (run) begin
                if (last) state_q <= IDLE;
                else rem_q <= rem_q - 9'd1;
            end
        end
    end
    assign o_load  = run & (op_q == OP_LOAD);
    assign o_inc   = run & (op_q == OP_UP);
    assign o_d_in  = o_load ? arg_q : 8'd0;
    assign o_busy  = state_q == EXEC;
    assign o_level = level_q;
`ifdef CNTR8_CMD_SEQ_OVF_EN
    logic err_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else if (cmd_valid & ~cmd_ready) err_q <= 1'b1;
    end
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_cntr8_cmd_seq.sv
// tb_cntr8_cmd_seq: vector, directed and model-based random checks for cntr8_cmd_seq
module tb_cntr8_cmd_seq;
`ifdef CNTR8_CMD_SEQ_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_arg = 8'd0;
    logic       i_hold = 1'b0;
    logic       o_load, o_inc, o_busy, o_err;
    logic [7:0] o_d_in;
    logic [2:0] o_level;
    int checks = 0;
    int failures = 0;

    cntr8_cmd_seq #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .i_hold(i_hold), .o_load(o_load),
        .o_inc(o_inc), .o_d_in(o_d_in), .o_busy(o_busy), .o_level(o_level), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [7:0] a;
        logic       h;
        logic       ld;
        logic       inc;
        logic [7:0] d;
        logic       busy;
        logic [2:0] lvl;
        logic       rdy;
    } vec_t;

    function automatic vec_t mk(int v, int op, int a, int h, int ld, int inc, int d, int b, int l, int r);
        mk.v = v[0]; mk.op = op[1:0]; mk.a = a[7:0]; mk.h = h[0];
        mk.ld = ld[0]; mk.inc = inc[0]; mk.d = d[7:0]; mk.busy = b[0]; mk.lvl = l[2:0]; mk.rdy = r[0];
    endfunction

    function automatic logic [15:0] outs();
        return {o_load, o_inc, o_d_in, o_busy, o_level, cmd_ready, o_err};
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drv(logic v, logic [1:0] op, logic [7:0] a, logic h);
        cmd_valid = v; cmd_op = op; cmd_arg = a; i_hold = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    vec_t tv[24];
    logic [9:0] q[$];
    logic       m_busy, m_err;
    logic [1:0] m_op;
    logic [7:0] m_arg;
    int         m_rem;

    initial begin
        int n_inc, n_busy, bad;
        tv[0]  = mk(1, 1, 'h5A, 0,  0, 0, 'h00, 0, 0, 1);
        tv[1]  = mk(0, 0, 0,    0,  0, 0, 'h00, 0, 1, 1);
        tv[2]  = mk(0, 0, 0,    0,  1, 0, 'h5A, 1, 0, 1);
        tv[3]  = mk(0, 0, 0,    0,  0, 0, 'h00, 0, 0, 1);
        tv[4]  = mk(1, 1, 'h10, 0,  0, 0, 'h00, 0, 0, 1);
        tv[5]  = mk(1, 2, 3,    0,  0, 0, 'h00, 0, 1, 1);
        tv[6]  = mk(1, 3, 2,    0,  1, 0, 'h10, 1, 1, 1);
        tv[7]  = mk(0, 0, 0,    0,  0, 1, 'h00, 1, 1, 1);
        tv[8]  = mk(0, 0, 0,    0,  0, 1, 'h00, 1, 1, 1);
        tv[9]  = mk(0, 0, 0,    0,  0, 1, 'h00, 1, 1, 1);
        tv[10] = mk(0, 0, 0,    0,  0, 0, 'h00, 1, 0, 1);
        tv[11] = mk(0, 0, 0,    0,  0, 0, 'h00, 1, 0, 1);
        tv[12] = mk(0, 0, 0,    0,  0, 0, 'h00, 0, 0, 1);
        tv[13] = mk(1, 2, 5,    0,  0, 0, 'h00, 0, 0, 1);
        tv[14] = mk(0, 0, 0,    0,  0, 0, 'h00, 0, 1, 1);
        tv[15] = mk(0, 0, 0,    0,  0, 1, 'h00, 1, 0, 1);
        tv[16] = mk(0, 0, 0,    0,  0, 1, 'h00, 1, 0, 1);
        tv[17] = mk(0, 0, 0,    1,  0, 0, 'h00, 1, 0, 1);
        tv[18] = mk(0, 0, 0,    1,  0, 0, 'h00, 1, 0, 1);
        tv[19] = mk(0, 0, 0,    1,  0, 0, 'h00, 1, 0, 1);
        tv[20] = mk(0, 0, 0,    0,  0, 1, 'h00, 1, 0, 1);
        tv[21] = mk(0, 0, 0,    0,  0, 1, 'h00, 1, 0, 1);
        tv[22] = mk(0, 0, 0,    0,  0, 1, 'h00, 1, 0, 1);
        tv[23] = mk(0, 0, 0,    0,  0, 0, 'h00, 0, 0, 1);

        #3;
        chk("reset_state", outs(), 16'h0002);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            drv(tv[i].v, tv[i].op, tv[i].a, tv[i].h);
            #1;
            chk($sformatf("vec%0d", i), outs(),
                {tv[i].ld, tv[i].inc, tv[i].d, tv[i].busy, tv[i].lvl, tv[i].rdy, 1'b0});
            tick();
        end

        drv(1'b1, 2'd2, 8'd0, 1'b0);
        tick();
        drv(1'b0, 2'd0, 8'd0, 1'b0);
        tick();
        n_inc = 0;
        n_busy = 0;
        for (int k = 0; k < 300 && o_busy; k++) begin
            n_inc += int'(o_inc);
            n_busy++;
            tick();
        end
        chk("up0_inc_cycles", 16'(n_inc), 16'd256);
        chk("up0_busy_cycles", 16'(n_busy), 16'd256);
        chk("up0_idle_after", 16'(o_busy), 16'd0);

        for (int k = 0; k < 4; k++) begin
            drv(1'b1, 2'd0, 8'd0, 1'b1);
            tick();
        end
        chk("fill_level", 16'(o_level), 16'd4);
        chk("fill_ready", 16'(cmd_ready), 16'd0);
        chk("fill_err_before", 16'(o_err), 16'd0);
        drv(1'b1, 2'd0, 8'd0, 1'b1);
        tick();
        drv(1'b0, 2'd0, 8'd0, 1'b1);
        #1;
        chk("ovf_err", 16'(o_err), 16'(OVF));
        chk("ovf_level", 16'(o_level), 16'd4);
        drv(1'b0, 2'd0, 8'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("drain%0d", k), 16'({o_busy, o_inc, o_load, o_level}), 16'({1'b1, 1'b0, 1'b0, 3'(3 - k)}));
        end
        tick();
        chk("drain_idle", 16'({o_busy, o_level}), 16'd0);
        chk("err_sticky", 16'(o_err), 16'(OVF));

        drv(1'b1, 2'd3, 8'd10, 1'b0);
        tick();
        drv(1'b1, 2'd2, 8'd3, 1'b0);
        tick();
        drv(1'b1, 2'd1, 8'h77, 1'b0);
        tick();
        drv(1'b0, 2'd0, 8'd0, 1'b0);
        #1;
        chk("pre_reset_busy", 16'({o_busy, o_level}), 16'({1'b1, 3'd2}));
        #1 reset = 1'b1;
        #1;
        chk("async_reset", outs(), 16'h0002);
        tick();
        tick();
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (o_busy || o_load || o_inc || o_level != 3'd0) bad++;
            tick();
        end
        chk("no_exec_after_reset", 16'(bad), 16'd0);

        m_busy = 1'b0;
        m_err = 1'b0;
        m_op = 2'd0;
        m_arg = 8'd0;
        m_rem = 0;
        q.delete();
        for (int c = 0; c < 600; c++) begin
            logic v, h, rdy, eld, einc;
            logic [1:0] op;
            logic [7:0] a;
            v = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 39) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            h = ($urandom_range(0, 5) == 0);
            drv(v, op, a, h);
            #1;
            rdy = q.size() != 4;
            eld = m_busy && !h && m_op == 2'd1;
            einc = m_busy && !h && m_op == 2'd2;
            chk($sformatf("rand%0d", c), outs(),
                {eld, einc, eld ? m_arg : 8'd0, m_busy, 3'(q.size()), rdy, m_err});
            if (m_busy && !h) begin
                m_rem--;
                if (m_rem == 0) m_busy = 1'b0;
            end
            if (!h && !m_busy && q.size() > 0) begin
                {m_op, m_arg} = q.pop_front();
                m_rem = (m_op == 2'd2 || m_op == 2'd3) ? ((m_arg == 8'd0) ? 256 : int'(m_arg)) : 1;
                m_busy = 1'b1;
            end
            if (v && rdy) q.push_back({op, a});
            if (v && !rdy && OVF) m_err = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cntr8_cmd_seq.md
Name: cntr8_cmd_seq

Overview:
- Command sequencer sitting directly upstream of the 8-bit loadable up/down counter (cntr8).
- Accepts queued counter commands over a valid/ready interface and buffers them in a small FIFO.
- Expands each command into the per-cycle load/inc/d_in drive the counter consumes.
- Lets software-style scripts (load X, count up N, count down M) run without cycle-exact stimulus.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
- AW, 2, FIFO address width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present on cmd_op/cmd_arg
- cmd_ready  output  1  FIFO can accept a command this cycle
- cmd_op  input  2  00 NOP, 01 LOAD, 10 UP, 11 DOWN
- cmd_arg  input  8  LOAD value, or UP/DOWN step count (0 means 256)
- i_hold  input  1  pause execution
- o_load  output  1  to counter load
- o_inc  output  1  to counter inc
- o_d_in  output  8  to counter d_in
- o_busy  output  1  a command is executing
- o_level  output  AW+1  FIFO occupancy
- o_err  output  1  sticky overflow flag; optional, see below

Behaviour:
- Reset (async, active-high):
  - FIFO emptied, state IDLE.
  - o_load=0, o_inc=0, o_d_in=0, o_busy=0, o_level=0, o_err=0.
  - cmd_ready=1 once reset deasserts.
- Push:
  - cmd_ready = (level != DEPTH), combinational from occupancy only.
  - Entry written on a clk edge with cmd_valid & cmd_ready.
  - Full FIFO: cmd_ready=0 even if a pop occurs the same cycle; no write-through when full.
- FSM: IDLE, EXEC.
  - IDLE: if level>0 and !i_hold, pop the head at the next edge into cur_op/cur_arg.
    - Remaining-count register is 9 bits, loaded with cur_arg, or 256 if cur_arg==0.
    - Go to EXEC.
  - EXEC drive, per op:
    - LOAD: o_load=1, o_inc=0, o_d_in=cur_arg for exactly 1 cycle.
    - UP: o_load=0, o_inc=1, o_d_in=0 for `remaining` cycles.
    - DOWN: o_load=0, o_inc=0, o_d_in=0 for `remaining` cycles.
    - NOP: all drive outputs 0 for 1 cycle.
  - Completion: on the last EXEC cycle, if level>0 and !i_hold, pop the next entry at the same edge (back-to-back, no bubble); otherwise return to IDLE.
- Latency:
  - Command pushed into an empty FIFO at edge N drives the outputs from edge N+1.
  - No same-cycle bypass.
- o_busy=1 exactly while in EXEC.
- Drive outputs are combinational from the state/cur registers only, never from cmd_* inputs.
- i_hold=1:
  - Drive outputs forced to 0 (o_load=0, o_inc=0, o_d_in=0).
  - Remaining count frozen, no pop; state and o_busy unchanged.
  - Resumes the same command, with remaining count intact, on the cycle after i_hold falls.
- Simultaneous push and pop: level unchanged; pointers wrap modulo DEPTH.
- Reset mid-command: current command and all queued entries are discarded immediately.

Optional Feature:
- Macro: CNTR8_CMD_SEQ_OVF_EN
- Defined:
  - o_err is set on any edge where cmd_valid=1 and cmd_ready=0 (rejected attempt).
  - Stays set until reset.
- Undefined:
  - o_err is tied to 0; port still present; no extra logic.

Test Plan:
- Reset, push LOAD 0x5A:
  - Push at edge 1 -> o_load=1, o_d_in=0x5A during cycle after edge 2 only.
  - o_busy high 1 cycle, then IDLE, o_level back to 0.
- Push LOAD 0x10, UP 3, DOWN 2 back-to-back:
  - Outputs 1 cycle load, 3 cycles o_inc=1, 2 cycles o_inc=0 with o_busy=1.
  - Contiguous 6 busy cycles, no bubble.
- Push UP with cmd_arg=0 -> o_inc=1 for exactly 256 consecutive cycles, then o_busy=0.
- Fill FIFO with 4 NOPs while i_hold=1:
  - o_level=4, cmd_ready=0.
  - Fifth push attempt sets o_err=1 with macro, o_err=0 without.
  - Release hold -> 4 busy cycles, level steps 4->3->2->1->0.
- During UP 5, assert i_hold for 3 cycles after 2 inc cycles:
  - Outputs 0 for 3 cycles, then exactly 3 more o_inc=1 cycles.
- Assert reset during DOWN 10 with 2 queued entries:
  - All outputs 0 asynchronously, o_level=0.
  - No remaining queued commands are executed after reset release.
